// File: rtl/inst_loader.sv
// Instruction loader: receives a count-prefixed, XOR-checksummed byte stream,
// writes it into a 128 x 16-bit instruction RAM and releases the CPU from
// reset only once the image checksum has been verified.
//
// state | meaning
// ------+-----------------------------------------------------------
// LEN   | waiting for the word-count byte (0 means 128 words)
// HI    | waiting for the high byte of the next word
// LO    | waiting for the low byte; the word is written on acceptance
// CHK   | waiting for the checksum byte
// RUN   | image verified, CPU running
// ERR   | checksum mismatch, CPU held in reset until load_req
module inst_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        load_req,
  input  logic [6:0]  inst_addr_i,
  output logic [15:0] inst_o,
  output logic        cpu_rst_n,
  output logic        load_done,
  output logic        load_err,
  output logic [7:0]  words_loaded
);

  typedef enum logic [2:0] {
    S_LEN = 3'd0,
    S_HI  = 3'd1,
    S_LO  = 3'd2,
    S_CHK = 3'd3,
    S_RUN = 3'd4,
    S_ERR = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] mem [128];
  logic [6:0]  wr_ptr;
  logic [6:0]  last_idx;
  logic [7:0]  hi_byte;
  logic [7:0]  csum;
  logic [7:0]  wl_cnt;
  logic        accept;

  // A byte handshaken together with load_req is dropped.
  assign accept       = byte_valid && byte_ready && !load_req;
  assign inst_o       = mem[inst_addr_i];
  assign words_loaded = wl_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_LEN;
    else     state <= state_nxt;
  end

  // Next-state logic; load_req overrides everything.
  always_comb begin
    state_nxt = state;
    if (load_req) begin
      state_nxt = S_LEN;
    end else if (accept) begin
      case (state)
        S_LEN:   state_nxt = S_HI;
        S_HI:    state_nxt = S_LO;
        S_LO:    state_nxt = (wr_ptr == last_idx) ? S_CHK : S_HI;
        S_CHK:   state_nxt = (byte_data == csum) ? S_RUN : S_ERR;
        default: state_nxt = state;
      endcase
    end
  end

  // Outputs decoded from the registered state (byte_ready also gated by rst).
  always_comb begin
    byte_ready = 1'b0;
    cpu_rst_n  = 1'b0;
    load_done  = 1'b0;
    load_err   = 1'b0;
    case (state)
      S_LEN, S_HI, S_LO, S_CHK: byte_ready = !rst;
      S_RUN: begin
        cpu_rst_n = 1'b1;
        load_done = 1'b1;
      end
      S_ERR:   load_err = 1'b1;
      default: ;
    endcase
  end

  // Load datapath: write pointer, held high byte, running checksum, counters.
  // last_idx keeps N-1 in 7 bits so a count of 0 ends after index 127.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= 7'd0;
      last_idx <= 7'd0;
      hi_byte  <= 8'd0;
      csum     <= 8'd0;
      wl_cnt   <= 8'd0;
    end else if (load_req) begin
      wr_ptr <= 7'd0;
      csum   <= 8'd0;
    end else if (accept) begin
      case (state)
        S_LEN: begin
          last_idx <= byte_data[6:0] - 7'd1;
          wr_ptr   <= 7'd0;
          csum     <= 8'd0;
          wl_cnt   <= 8'd0;
        end
        S_HI: begin
          hi_byte <= byte_data;
          csum    <= csum ^ byte_data;
        end
        S_LO: begin
          csum   <= csum ^ byte_data;
          wr_ptr <= wr_ptr + 7'd1;
          wl_cnt <= wl_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Instruction RAM write port; contents are never cleared by reset.
  always_ff @(posedge clk) begin
    if (accept && state == S_LO) mem[wr_ptr] <= {hi_byte, byte_data};
  end

endmodule
